// File: rtl/irq_controller.sv
// Purpose: synchronise external interrupt lines, hold pending/mask/mode state and raise one prioritised request to the core.
// Latency: an edge-mode input first sampled at edge E0 sets pending at E0+2, and o_irq_req is high after E0+3 (SYNC_STAGES = 2).
// Backpressure: a request is held stable until i_irq_ack. Arbitration stays suppressed until i_eret ends SERVICE.
module irq_controller #(
    parameter int NUM_IRQ     = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] i_interruption,
    input  logic               i_cfg_we,
    input  logic               i_cfg_sel,
    input  logic [NUM_IRQ-1:0] i_cfg_wdata,
    input  logic               i_irq_ack,
    input  logic               i_eret,
    output logic               o_irq_req,
    output logic [2:0]         o_irq_id,
    output logic [NUM_IRQ-1:0] o_pending,
    output logic [NUM_IRQ-1:0] o_mask,
    output logic [NUM_IRQ-1:0] o_mode,
    output logic               o_in_service
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

    // Stage 0 takes the raw line. The last stage is the synchronised view.
    logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] sync_q;
    logic [NUM_IRQ-1:0]                  prev_q;
    logic [NUM_IRQ-1:0]                  pending_q, pending_d;
    logic [NUM_IRQ-1:0]                  mask_q, mode_q;
    logic [NUM_IRQ-1:0]                  sync_w, rise_w, clr_w, eligible_w;
    logic [2:0]                          winner_w;
    logic                                ack_take_w;
    state_t                              state_q;
    logic                                req_q, in_service_q;
    logic [2:0]                          id_q;

    assign sync_w     = sync_q[SYNC_STAGES-1];
    assign rise_w     = sync_w & ~prev_q;
    assign ack_take_w = (state_q == ST_REQ) && i_irq_ack;
    assign eligible_w = pending_q & mask_q;

    // Shift each raw line through its synchroniser and keep a one-cycle-old copy for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_interruption};
            prev_q <= sync_w;
        end
    end

    // An acknowledge clears only the line that is being served.
    always_comb begin
        clr_w = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr_w[i] = ack_take_w && (id_q == 3'(i));
        end
    end

    // Level lines follow the synchronised input. Edge lines latch a rise, and a rise wins over a same-cycle clear.
    always_comb begin
        pending_d = (mode_q & sync_w) | (~mode_q & (rise_w | (pending_q & ~clr_w)));
    end

    // Pending tracks the inputs whatever the mask is. The mask only gates arbitration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Fixed priority: the loop counts down so the lowest eligible index is the last written.
    always_comb begin
        winner_w = 3'd0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (eligible_w[i]) begin
                winner_w = 3'(i);
            end
        end
    end

    // Configuration writes land in the register and are seen by arbitration on the following cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            mode_q <= '0;
        end else if (i_cfg_we) begin
            if (i_cfg_sel) begin
                mode_q <= i_cfg_wdata;
            end else begin
                mask_q <= i_cfg_wdata;
            end
        end
    end

    // Request/service handshake with registered outputs. The ID is latched on entry to REQ and never preempted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            id_q         <= 3'd0;
            in_service_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|eligible_w) begin
                        state_q <= ST_REQ;
                        req_q   <= 1'b1;
                        id_q    <= winner_w;
                    end
                end
                ST_REQ: begin
                    // A same-cycle eret is ignored here because it only has meaning in SERVICE.
                    if (i_irq_ack) begin
                        state_q      <= ST_SERVICE;
                        req_q        <= 1'b0;
                        in_service_q <= 1'b1;
                    end
                end
                ST_SERVICE: begin
                    if (i_eret) begin
                        state_q      <= ST_IDLE;
                        in_service_q <= 1'b0;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    req_q        <= 1'b0;
                    in_service_q <= 1'b0;
                end
            endcase
        end
    end

    assign o_irq_req    = req_q;
    assign o_irq_id     = id_q;
    assign o_pending    = pending_q;
    assign o_mask       = mask_q;
    assign o_mode       = mode_q;
    assign o_in_service = in_service_q;

endmodule

// File: tb/tb_irq_controller.sv
// Purpose: self-checking bench for irq_controller. It runs directed vectors, reset corner cases and a random run against a reference model.
// Latency: the bench drives inputs 1 time unit after a rising edge and samples outputs 1 time unit after the next rising edge.
// Backpressure: the bench plays the core, pulsing ack and eret.
module tb_irq_controller;
    localparam int N = 5;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] irq;
    logic         cfg_we, cfg_sel, ack, eret;
    logic [N-1:0] cfg_wdata;
    logic         irq_req, in_service;
    logic [2:0]   irq_id;
    logic [N-1:0] pending, mask, mode;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    irq_controller #(.NUM_IRQ(N), .SYNC_STAGES(S)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_interruption (irq),
        .i_cfg_we       (cfg_we),
        .i_cfg_sel      (cfg_sel),
        .i_cfg_wdata    (cfg_wdata),
        .i_irq_ack      (ack),
        .i_eret         (eret),
        .o_irq_req      (irq_req),
        .o_irq_id       (irq_id),
        .o_pending      (pending),
        .o_mask         (mask),
        .o_mode         (mode),
        .o_in_service   (in_service)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Directed vectors: the inputs applied before an edge and the outputs expected after it.
    typedef struct {
        logic [N-1:0] irq;
        logic         we;
        logic         sel;
        logic [N-1:0] wd;
        logic         ack;
        logic         eret;
        logic         e_req;
        logic [2:0]   e_id;
        logic [N-1:0] e_pend;
        logic         e_srv;
        logic [N-1:0] e_mask;
        logic [N-1:0] e_mode;
    } vec_t;
    vec_t tbl[$];

    task automatic add(input logic [N-1:0] i_irq, input logic we, input logic sel, input logic [N-1:0] wd,
                       input logic a, input logic e, input logic rq, input logic [2:0] id,
                       input logic [N-1:0] pd, input logic sv, input logic [N-1:0] mk, input logic [N-1:0] md);
        vec_t v;
        v.irq = i_irq; v.we = we; v.sel = sel; v.wd = wd; v.ack = a; v.eret = e;
        v.e_req = rq; v.e_id = id; v.e_pend = pd; v.e_srv = sv; v.e_mask = mk; v.e_mode = md;
        tbl.push_back(v);
    endtask

    // Reference model. The synchroniser is a history of input samples: hist[k] is the sample taken k+1 edges ago.
    logic [N-1:0] m_hist [S+1];
    logic [N-1:0] m_pend, m_mask, m_mode;
    int           m_st;   // 0 idle, 1 request outstanding, 2 in service
    int           m_id;

    task automatic model_reset();
        for (int k = 0; k <= S; k++) m_hist[k] = '0;
        m_pend = '0; m_mask = '0; m_mode = '0; m_st = 0; m_id = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] a, input logic we, input logic sel, input logic [N-1:0] wd,
                              input logic ak, input logic er);
        logic [N-1:0] sy, pv, np, elig;
        int win;
        sy   = m_hist[S-1];
        pv   = m_hist[S];
        elig = m_pend & m_mask;
        win  = -1;
        for (int i = 0; i < N; i++) begin
            if (elig[i]) begin
                win = i;
                break;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (m_mode[i]) begin
                np[i] = sy[i];
            end else begin
                np[i] = m_pend[i];
                if (m_st == 1 && ak && m_id == i) np[i] = 1'b0;
                if (sy[i] && !pv[i]) np[i] = 1'b1;
            end
        end
        if (m_st == 0 && win >= 0) begin
            m_st = 1; m_id = win;
        end else if (m_st == 1 && ak) begin
            m_st = 2;
        end else if (m_st == 2 && er) begin
            m_st = 0;
        end
        if (we) begin
            if (sel) m_mode = wd;
            else     m_mask = wd;
        end
        for (int k = S; k >= 1; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = a;
        m_pend = np;
    endtask

    task automatic drive(input logic [N-1:0] i_irq, input logic we, input logic sel, input logic [N-1:0] wd,
                         input logic a, input logic e);
        irq = i_irq; cfg_we = we; cfg_sel = sel; cfg_wdata = wd; ack = a; eret = e;
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, "_req"}, 32'(irq_req), 32'd0);
        chk({tag, "_id"}, 32'(irq_id), 32'd0);
        chk({tag, "_pend"}, 32'(pending), 32'd0);
        chk({tag, "_mask"}, 32'(mask), 32'd0);
        chk({tag, "_mode"}, 32'(mode), 32'd0);
        chk({tag, "_srv"}, 32'(in_service), 32'd0);
    endtask

    initial begin
        bit got;
        reset = 1'b0; irq = '1; cfg_we = 0; cfg_sel = 0; cfg_wdata = '0; ack = 0; eret = 0;

        // Hold reset for 3 cycles with every line high, then release it with the mask still zero.
        repeat (3) @(posedge clk);
        #1;
        check_idle_zero("rst_hold");
        reset = 1'b1;
        drive('1, 0, 0, '0, 0, 0);
        check_idle_zero("rst_rel");
        for (int c = 0; c < 6; c++) begin
            drive('1, 0, 0, '0, 0, 0);
            chk("rst_mask0_noreq", 32'(irq_req), 32'd0);
        end

        // Start from a clean reset with every line low for the directed vectors.
        irq = '0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Line 2 edge: full request / ack / eret handshake.
        add(5'h00,1,0,5'h1F,0,0, 0,0,5'h00,0,5'h1F,5'h00);
        add(5'h04,0,0,5'h00,0,0, 0,0,5'h00,0,5'h1F,5'h00);
        add(5'h04,0,0,5'h00,0,0, 0,0,5'h00,0,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,0,0, 0,0,5'h04,0,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,0,0, 1,2,5'h04,0,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,1,0, 0,0,5'h00,1,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,0,0, 0,0,5'h00,1,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,0,1, 0,0,5'h00,0,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,0,0, 0,0,5'h00,0,5'h1F,5'h00);
        // Lines 1 and 3 rise together: line 1 is served first, then line 3.
        add(5'h0A,0,0,5'h00,0,0, 0,0,5'h00,0,5'h1F,5'h00);
        add(5'h0A,0,0,5'h00,0,0, 0,0,5'h00,0,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,0,0, 0,0,5'h0A,0,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,0,0, 1,1,5'h0A,0,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,1,0, 0,0,5'h08,1,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,0,1, 0,0,5'h08,0,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,0,0, 1,3,5'h08,0,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,1,0, 0,0,5'h00,1,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,0,1, 0,0,5'h00,0,5'h1F,5'h00);
        // Line 0 is masked: it goes pending with no request, and unmasking it raises one an edge later.
        add(5'h00,1,0,5'h1E,0,0, 0,0,5'h00,0,5'h1E,5'h00);
        add(5'h01,0,0,5'h00,0,0, 0,0,5'h00,0,5'h1E,5'h00);
        add(5'h01,0,0,5'h00,0,0, 0,0,5'h00,0,5'h1E,5'h00);
        add(5'h00,0,0,5'h00,0,0, 0,0,5'h01,0,5'h1E,5'h00);
        add(5'h00,0,0,5'h00,0,0, 0,0,5'h01,0,5'h1E,5'h00);
        add(5'h00,1,0,5'h1F,0,0, 0,0,5'h01,0,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,0,0, 1,0,5'h01,0,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,1,0, 0,0,5'h00,1,5'h1F,5'h00);
        add(5'h00,0,0,5'h00,0,1, 0,0,5'h00,0,5'h1F,5'h00);
        // Line 4 in level mode: it re-requests after eret, a same-cycle ack+eret takes the ack, and dropping the line ends it.
        add(5'h00,1,1,5'h10,0,0, 0,0,5'h00,0,5'h1F,5'h10);
        add(5'h10,0,0,5'h00,0,0, 0,0,5'h00,0,5'h1F,5'h10);
        add(5'h10,0,0,5'h00,0,0, 0,0,5'h00,0,5'h1F,5'h10);
        add(5'h10,0,0,5'h00,0,0, 0,0,5'h10,0,5'h1F,5'h10);
        add(5'h10,0,0,5'h00,0,0, 1,4,5'h10,0,5'h1F,5'h10);
        add(5'h10,0,0,5'h00,1,0, 0,0,5'h10,1,5'h1F,5'h10);
        add(5'h10,0,0,5'h00,0,1, 0,0,5'h10,0,5'h1F,5'h10);
        add(5'h10,0,0,5'h00,0,0, 1,4,5'h10,0,5'h1F,5'h10);
        add(5'h10,0,0,5'h00,1,1, 0,0,5'h10,1,5'h1F,5'h10);
        add(5'h00,0,0,5'h00,0,0, 0,0,5'h10,1,5'h1F,5'h10);
        add(5'h00,0,0,5'h00,0,0, 0,0,5'h10,1,5'h1F,5'h10);
        add(5'h00,0,0,5'h00,0,0, 0,0,5'h00,1,5'h1F,5'h10);
        add(5'h00,0,0,5'h00,0,1, 0,0,5'h00,0,5'h1F,5'h10);
        add(5'h00,0,0,5'h00,0,0, 0,0,5'h00,0,5'h1F,5'h10);
        add(5'h00,0,0,5'h00,0,0, 0,0,5'h00,0,5'h1F,5'h10);

        for (int r = 0; r < tbl.size(); r++) begin
            drive(tbl[r].irq, tbl[r].we, tbl[r].sel, tbl[r].wd, tbl[r].ack, tbl[r].eret);
            chk($sformatf("vec%0d_req", r), 32'(irq_req), 32'(tbl[r].e_req));
            if (tbl[r].e_req) chk($sformatf("vec%0d_id", r), 32'(irq_id), 32'(tbl[r].e_id));
            chk($sformatf("vec%0d_pend", r), 32'(pending), 32'(tbl[r].e_pend));
            chk($sformatf("vec%0d_srv", r), 32'(in_service), 32'(tbl[r].e_srv));
            chk($sformatf("vec%0d_mask", r), 32'(mask), 32'(tbl[r].e_mask));
            chk($sformatf("vec%0d_mode", r), 32'(mode), 32'(tbl[r].e_mode));
        end

        // Get into SERVICE with every line high, then assert reset between clock edges.
        got = 0;
        for (int c = 0; c < 10 && !got; c++) begin
            drive('1, 0, 0, '0, 0, 0);
            if (irq_req) got = 1;
        end
        chk("svc_reach_req", 32'(got), 32'd1);
        drive('1, 0, 0, '0, 1, 0);
        chk("svc_in_service", 32'(in_service), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_idle_zero("async_rst");
        @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive('1, 0, 0, '0, 0, 0);
            chk("post_rst_noreq", 32'(irq_req), 32'd0);
            chk("post_rst_nosrv", 32'(in_service), 32'd0);
        end

        // Random run against the reference model, starting from a fresh reset.
        irq = '0; cfg_we = 0; ack = 0; eret = 0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] ni, nw;
            logic we, sel, a, e;
            ni  = ($urandom_range(0, 3) == 0) ? N'($urandom) : irq;
            we  = ($urandom_range(0, 9) == 0) || (c == 0);
            sel = (c == 0) ? 1'b0 : 1'($urandom);
            nw  = (c == 0) ? '1 : (sel ? N'($urandom) : (N'($urandom) | N'($urandom)));
            a   = ($urandom_range(0, 3) == 0);
            e   = ($urandom_range(0, 3) == 0);
            drive(ni, we, sel, nw, a, e);
            model_edge(ni, we, sel, nw, a, e);
            chk("rnd_req", 32'(irq_req), 32'(m_st == 1));
            chk("rnd_srv", 32'(in_service), 32'(m_st == 2));
            chk("rnd_pend", 32'(pending), 32'(m_pend));
            chk("rnd_mask", 32'(mask), 32'(m_mask));
            chk("rnd_mode", 32'(mode), 32'(m_mode));
            if (m_st == 1) chk("rnd_id", 32'(irq_id), 32'(m_id));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
